// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter with valid/ready load and framing strobes
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             done,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic last, load;
  assign last = (state == SHIFT) && (cnt == LAST);
  // ready gated by reset so nothing is accepted while the block is held in reset
  assign load_ready = ~reset & ((state == IDLE) | last);
  assign load = load_valid & load_ready;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sh    <= sh_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    if (load) begin
      state_n = SHIFT;
      cnt_n   = '0;
      sh_n    = data;
    end else if (state == SHIFT) begin
      state_n = last ? IDLE : SHIFT;
      cnt_n   = last ? '0 : cnt + CW'(1);
      sh_n    = LSB_FIRST ? {1'b0, sh[WIDTH-1:1]} : {sh[WIDTH-2:0], 1'b0};
    end
  end
  assign busy        = (state == SHIFT);
  assign ser_valid   = busy;
  assign ser_out     = busy & (LSB_FIRST ? sh[0] : sh[WIDTH-1]);
  assign frame_start = busy & (cnt == '0);
  assign done        = last;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench driving MSB-first and LSB-first instances in lockstep
module tb_piso_serializer;
  localparam int W = 8;
  typedef struct packed {logic b; logic fs; logic dn;} ent_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [W-1:0] data = '0;
  logic load_valid = 1'b0;
  logic [1:0] lr, so, sv, fs, dn, by;
  ent_t q0[$], q1[$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .data(data), .load_valid(load_valid), .load_ready(lr[0]),
    .ser_out(so[0]), .ser_valid(sv[0]), .frame_start(fs[0]), .done(dn[0]), .busy(by[0])
  );
  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut1 (
    .clk(clk), .reset(reset), .data(data), .load_valid(load_valid), .load_ready(lr[1]),
    .ser_out(so[1]), .ser_valid(sv[1]), .frame_start(fs[1]), .done(dn[1]), .busy(by[1])
  );
  task automatic chk(input int k, input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL dut%0d %s: observed %b expected %b", k, tag, obs, exp);
    end
  endtask
  task automatic chk_outs(input logic exp_ready);
    for (int k = 0; k < 2; k++) begin
      chk(k, "ser_out", so[k], 1'b0);
      chk(k, "ser_valid", sv[k], 1'b0);
      chk(k, "frame_start", fs[k], 1'b0);
      chk(k, "done", dn[k], 1'b0);
      chk(k, "busy", by[k], 1'b0);
      chk(k, "load_ready", lr[k], exp_ready);
    end
  endtask
  task automatic check_cycle();
    for (int k = 0; k < 2; k++) begin
      ent_t e;
      logic has;
      has = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
      e = '0;
      if (has) e = (k == 0) ? q0.pop_front() : q1.pop_front();
      chk(k, "ser_valid", sv[k], has);
      chk(k, "busy", by[k], has);
      chk(k, "ser_out", so[k], e.b);
      chk(k, "frame_start", fs[k], e.fs);
      chk(k, "done", dn[k], e.dn);
      chk(k, "load_ready", lr[k], ((k == 0) ? q0.size() : q1.size()) == 0);
    end
  endtask
  // model: a load happens when the upstream is valid and no bits remain after the one on the wire
  task automatic step();
    if (load_valid && q0.size() == 0)
      for (int i = 0; i < W; i++) begin
        q0.push_back('{b: data[W-1-i], fs: (i == 0), dn: (i == W-1)});
        q1.push_back('{b: data[i], fs: (i == 0), dn: (i == W-1)});
      end
    @(posedge clk);
    @(negedge clk);
    check_cycle();
  endtask
  initial begin
    #3 chk_outs(1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk_outs(1'b1);
    // single word 0xA5, then idle
    data = 8'hA5; load_valid = 1'b1;
    step();
    load_valid = 1'b0; data = 8'h00;
    repeat (9) step();
    // 0xC1: LSB-first instance sends 1,0,0,0,0,0,1,1
    data = 8'hC1; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    repeat (9) step();
    // back-to-back 0x0F then 0xF0
    data = 8'h0F; load_valid = 1'b1;
    step();
    data = 8'hF0;
    repeat (8) step();
    load_valid = 1'b0;
    repeat (9) step();
    // data/valid wiggled mid-word must not disturb 0x3C
    data = 8'h3C; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    data = 8'hFF; load_valid = 1'b1;
    repeat (4) step();
    load_valid = 1'b0; data = 8'h00;
    repeat (5) step();
    // async reset mid-word
    data = 8'hA5; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    repeat (2) step();
    #2 reset = 1'b1;
    #1 chk_outs(1'b0);
    q0.delete();
    q1.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 chk_outs(1'b1);
    repeat (4) step();
    // recovery load after reset
    data = 8'h5A; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    repeat (9) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
